// File: rtl/ringbuffer_frame_reader_pkg.sv
// Shared definitions for the ringbuffer frame reader, the host-side decoder
// and the bench: FSM state encodings, default SYNC word and frame word offsets.
// Build option: RINGBUFFER_FRAME_CHECKSUM_EN adds the trailing CHK word.
package ringbuffer_frame_reader_pkg;

    // 3-bit state encodings, kept as plain localparams so non-SV tools can reuse them
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_LEN     = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SYNC    = ST_SYNC,
        S_PAYLOAD = ST_PAYLOAD,
        S_LEN     = ST_LEN,
        S_CHK     = ST_CHK
    } state_e;

    localparam logic [7:0] DEF_SYNC = 8'hA5;

    // Word offsets within a frame carrying n payload words
    localparam int OFF_SYNC    = 0;
    localparam int OFF_PAYLOAD = 1;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
    localparam int TRAILER_WORDS = 2;  // LEN + CHK
`else
    localparam int TRAILER_WORDS = 1;  // LEN only
`endif

    function automatic int len_offset(input int n);
        return OFF_PAYLOAD + n;
    endfunction

    function automatic int frame_words(input int n);
        return OFF_PAYLOAD + n + TRAILER_WORDS;
    endfunction

endpackage

// File: rtl/ringbuffer_frame_reader_stream_out_reg.sv
// stream_out_reg: single-entry valid/ready output register.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_i              upstream presents a word this cycle (only honoured on load_o)
//   data_i, last_i    word and end-of-frame marker to register
//   ready_i           downstream accept
//   load_o            register can take a new word this cycle
//   valid_o, data_o, last_o   registered stream outputs
module stream_out_reg
    import ringbuffer_frame_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             load_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    // Empty, or the current word leaves this cycle
    assign load_o = !valid_q || ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_o) begin
            valid_q <= wr_i;
            last_q  <= wr_i && last_i;
            if (wr_i) data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/ringbuffer_frame_reader.sv
// ringbuffer_frame_reader: drains a first-word-fall-through ringbuffer into
// framed packets (SYNC, payload, LEN[, CHK]) on a valid/ready word stream.
// A frame launches on rb_half_full or after TIMEOUT cycles of waiting data.
// Build option: RINGBUFFER_FRAME_CHECKSUM_EN appends CHK = -(payload+LEN),
// with out_last on CHK; otherwise out_last is on LEN.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   rb_empty, rb_half_full, rb_data  ringbuffer read side (head word)
//   rb_pop                           combinational pop of the head word
//   out_valid, out_data, out_last, out_ready   output stream
//   frame_count                      completed frames, wraps at 2^16
module ringbuffer_frame_reader
    import ringbuffer_frame_reader_pkg::*;
#(
    parameter int             WIDTH   = 8,
    parameter int             MAX_LEN = 16,
    parameter int             TIMEOUT = 64,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DEF_SYNC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rb_empty,
    input  logic             rb_half_full,
    input  logic [WIDTH-1:0] rb_data,
    output logic             rb_pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [15:0]      frame_count
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    fcnt_q, fcnt_d;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
`endif

    logic             load;
    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             wlast;
    logic             pop;
    logic [WIDTH-1:0] len_word;

    assign len_word = WIDTH'(count_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            timer_q <= '0;
            fcnt_q  <= '0;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            fcnt_q  <= fcnt_d;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        fcnt_d  = fcnt_q;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        wr    = 1'b0;
        wdata = '0;
        wlast = 1'b0;
        pop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // half_full and timeout together are still one trigger
                if (rb_half_full || (!rb_empty && timer_q == TW'(TIMEOUT - 1))) begin
                    state_d = S_SYNC;
                    timer_d = '0;
                end else if (rb_empty) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SYNC: begin
                if (load) begin
                    wr      = 1'b1;
                    wdata   = SYNC;
                    count_d = '0;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // Underrun closes the frame short; count==0 && empty just waits
                if (count_q == CW'(MAX_LEN) || (rb_empty && count_q != '0)) begin
                    state_d = S_LEN;
                end else if (load && !rb_empty) begin
                    pop     = 1'b1;
                    wr      = 1'b1;
                    wdata   = rb_data;
                    count_d = count_q + CW'(1);
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
                    csum_d  = csum_q + rb_data;
`endif
                end
            end
            S_LEN: begin
                if (load) begin
                    wr    = 1'b1;
                    wdata = len_word;
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
                    csum_d  = csum_q + len_word;
                    state_d = S_CHK;
`else
                    wlast   = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
            S_CHK: begin
                if (load) begin
                    wr      = 1'b1;
                    wdata   = '0 - csum_q;  // makes payload+LEN+CHK sum to zero
                    wlast   = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Pop is gated by reset so nothing is consumed while rst_n is low
    assign rb_pop      = pop && rst_n;
    assign frame_count = fcnt_q;

    stream_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (wr),
        .data_i  (wdata),
        .last_i  (wlast),
        .ready_i (out_ready),
        .load_o  (load),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last)
    );

endmodule

// File: tb/tb_ringbuffer_frame_reader.sv
module tb_ringbuffer_frame_reader;
    import ringbuffer_frame_reader_pkg::*;

    localparam int DEPTH = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rb_empty = 1'b1;
    logic        rb_half_full = 1'b0;
    logic [7:0]  rb_data = 8'h00;
    logic        out_ready = 1'b1;
    logic        rb_pop;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    ringbuffer_frame_reader #(.WIDTH(8), .MAX_LEN(16), .TIMEOUT(64), .SYNC(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rb_empty     (rb_empty),
        .rb_half_full (rb_half_full),
        .rb_data      (rb_data),
        .rb_pop       (rb_pop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .frame_count  (frame_count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic [7:0] fifo[$];
    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         rand_ready = 1'b0;
    bit         pop_flag;
    int         pop_total = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic update_rb();
        rb_empty     = (fifo.size() == 0);
        rb_half_full = (fifo.size() >= DEPTH / 2);
        rb_data      = rb_empty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] v);
        fifo.push_back(v);
        update_rb();
    endtask

    task automatic expect_word(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Frame of n consecutive payload words starting at 'start'
    task automatic expect_frame(input logic [7:0] start, input int n);
        logic [7:0] sum;
        sum = 8'h00;
        expect_word(8'hA5, 1'b0);
        for (int i = 0; i < n; i++) begin
            expect_word(start + 8'(i), 1'b0);
            sum = sum + start + 8'(i);
        end
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
        expect_word(8'(n), 1'b0);
        sum = sum + 8'(n);
        expect_word(8'h00 - sum, 1'b1);
`else
        expect_word(8'(n), 1'b1);
`endif
    endtask

    // One clock: note the pop seen mid-cycle, then apply it to the model after the edge
    task automatic tick();
        @(negedge clk);
        pop_flag = rb_pop;
        @(posedge clk);
        #1;
        if (pop_flag) begin
            if (fifo.size() > 0) fifo.delete(0);
            pop_total++;
        end
        out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        update_rb();
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d words still expected, expected 0", name, exp_q.size());
        end
        repeat (3) tick();
    endtask

    // Monitor: compares every handshake against the scoreboard, plus protocol checks
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rb_pop && rb_empty) begin
                miscompares++;
                $display("FAIL pop_empty: rb_pop=1 with rb_empty=1, expected rb_pop=0");
            end
            if (rb_pop && out_valid && !out_ready) begin
                miscompares++;
                $display("FAIL pop_stall: rb_pop=1 while output stalled, expected rb_pop=0");
            end
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_word: got %h/%b expected no word", out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                if (out_data !== e.d || out_last !== e.l) begin
                    miscompares++;
                    $display("FAIL word: got %h last=%b expected %h last=%b",
                             out_data, out_last, e.d, e.l);
                end
            end
        end
        prev_stall = rst_n && out_valid === 1'b1 && out_ready === 1'b0;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    initial begin
        int base;
        int n;

        // Reset state
        update_rb();
        repeat (3) tick();
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_data",  16'(out_data),  16'd0);
        check("rst_last",  16'(out_last),  16'd0);
        check("rst_fcnt",  frame_count,    16'd0);
        check("rst_pop",   16'(rb_pop),    16'd0);
        rst_n = 1'b1;
        tick();

        // 1,2,3 then timeout: A5 01 02 03 03 F7 (sum 1+2+3+3=9, -9=F7)
        expect_word(8'hA5, 1'b0);
        expect_word(8'h01, 1'b0);
        expect_word(8'h02, 1'b0);
        expect_word(8'h03, 1'b0);
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
        expect_word(8'h03, 1'b0);
        expect_word(8'hF7, 1'b1);
`else
        expect_word(8'h03, 1'b1);
`endif
        push(8'h01); push(8'h02); push(8'h03);
        // No frame may start before the timeout expires
        repeat (40) tick();
        check("no_early", 16'(exp_q.size()), 16'(frame_words(3)));
        wait_drain("t1", 300);
        check("fcnt_t1", frame_count, 16'd1);

        // 50-word burst: 16,16,16 then 2 after the timeout
        expect_frame(8'd0, 16);
        expect_frame(8'd16, 16);
        expect_frame(8'd32, 16);
        expect_frame(8'd48, 2);
        for (int i = 0; i < 50; i++) push(8'(i));
        wait_drain("t2", 2000);
        check("fcnt_t2", frame_count, 16'd5);

        // Same burst with random back-pressure
        rand_ready = 1'b1;
        expect_frame(8'd0, 16);
        expect_frame(8'd16, 16);
        expect_frame(8'd32, 16);
        expect_frame(8'd48, 2);
        for (int i = 0; i < 50; i++) push(8'(i));
        wait_drain("t3", 4000);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) tick();
        check("fcnt_t3", frame_count, 16'd9);

        // Short frame of 5 (80..84: sum 28A +5 -> 8F, CHK 71), then a new frame
        expect_word(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) expect_word(8'h80 + 8'(i), 1'b0);
`ifdef RINGBUFFER_FRAME_CHECKSUM_EN
        expect_word(8'h05, 1'b0);
        expect_word(8'h71, 1'b1);
`else
        expect_word(8'h05, 1'b1);
`endif
        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
        wait_drain("t4a", 300);
        check("fcnt_t4a", frame_count, 16'd10);
        expect_frame(8'h10, 3);
        push(8'h10); push(8'h11); push(8'h12);
        wait_drain("t4b", 300);
        check("fcnt_t4b", frame_count, 16'd11);

        // Reset after 4 payload words: partial frame abandoned, rest re-framed
        expect_word(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) expect_word(8'h20 + 8'(i), 1'b0);
        expect_frame(8'h24, 6);
        for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
        base = pop_total;
        n = 0;
        while (pop_total - base < 4 && n < 300) begin
            tick();
            n++;
        end
        check("t5_pops", 16'(pop_total - base), 16'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid", 16'(out_valid),   16'd0);
        check("t5_fcnt",  frame_count,      16'd0);
        check("t5_pop",   16'(rb_pop),      16'd0);
        check("t5_left",  16'(fifo.size()), 16'd6);
        wait_drain("t5", 300);
        check("fcnt_t5", frame_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
